// File: rtl/hit_pkg.sv
// hit_pkg: shared definitions for the rhythm-game hit judge.
//   score_t          2-bit judgement code carried from lanes to the score output
//   SCORE_*          judgement code values
//   DEF_*            default timing-window offsets
//   lane_w()         width of a lane index (never below 1 bit)
package hit_pkg;

  typedef logic [1:0] score_t;

  localparam score_t SCORE_PERFECT = 2'b11;
  localparam score_t SCORE_LATE    = 2'b10;
  localparam score_t SCORE_EARLY   = 2'b01;
  localparam score_t SCORE_NONE    = 2'b00;

  localparam int DEF_EARLY_OFF = 1;
  localparam int DEF_PERF_LO   = 2;
  localparam int DEF_PERF_HI   = 4;
  localparam int DEF_LATE_OFF  = 5;
  localparam int DEF_MISS_OFF  = 6;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/judge_lane.sv
// judge_lane: one button/note lane.
//   Detects button presses, classifies the note offset into a judgement,
//   generates the auto-miss, and holds the result in a one-deep pending
//   register until the top level drains it.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   btn             debounced button level for this lane
//   note_present    a note sits in this lane's judge zone
//   offset          unsigned position of that note
//   drain           top level takes the pending result at this edge
//   delete_note     one-cycle pulse after a judged event
//   pend_valid      pending result is waiting to be drained
//   pend_code       pending judgement code
//   ovf_evt         a new event is about to overwrite an undrained result
module judge_lane
  import hit_pkg::*;
#(
  parameter int OFF_W     = 3,
  parameter int EARLY_OFF = DEF_EARLY_OFF,
  parameter int PERF_LO   = DEF_PERF_LO,
  parameter int PERF_HI   = DEF_PERF_HI,
  parameter int LATE_OFF  = DEF_LATE_OFF,
  parameter int MISS_OFF  = DEF_MISS_OFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             note_present,
  input  logic [OFF_W-1:0] offset,
  input  logic             drain,
  output logic             delete_note,
  output logic             pend_valid,
  output score_t           pend_code,
  output logic             ovf_evt
);

  // Window bounds are compared at the offset width, so wider parameter
  // values wrap rather than silently never matching.
  localparam logic [OFF_W-1:0] EARLY_T = OFF_W'(EARLY_OFF);
  localparam logic [OFF_W-1:0] PLO_T   = OFF_W'(PERF_LO);
  localparam logic [OFF_W-1:0] PHI_T   = OFF_W'(PERF_HI);
  localparam logic [OFF_W-1:0] LATE_T  = OFF_W'(LATE_OFF);
  localparam logic [OFF_W-1:0] MISS_T  = OFF_W'(MISS_OFF);

  logic   btn_q;
  logic   press;
  logic   judged;
  score_t hit_code;
  score_t new_code;

  assign press = btn & ~btn_q;

  // PERFECT window takes precedence if a misconfigured window overlaps
  // the LATE or EARLY offsets.
  always_comb begin
    hit_code = SCORE_NONE;
    if (offset >= PLO_T && offset <= PHI_T) hit_code = SCORE_PERFECT;
    else if (offset == LATE_T)              hit_code = SCORE_LATE;
    else if (offset == EARLY_T)             hit_code = SCORE_EARLY;
  end

  // A press on a present note is judged by its offset; an unpressed note
  // that reaches the miss offset is judged NONE.
  assign judged   = note_present & (press | (offset == MISS_T));
  assign new_code = press ? hit_code : SCORE_NONE;
  assign ovf_evt  = judged & pend_valid & ~drain;

  // Load beats drain when both happen at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q       <= 1'b0;
      delete_note <= 1'b0;
      pend_valid  <= 1'b0;
      pend_code   <= SCORE_NONE;
    end else begin
      btn_q       <= btn;
      delete_note <= judged;
      if (judged) begin
        pend_valid <= 1'b1;
        pend_code  <= new_code;
      end else if (drain) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hit_judge_multi.sv
// hit_judge_multi: multi-lane hit judge with a shared score output.
//   Each lane judges its own presses and auto-misses into a one-deep pending
//   register. Every cycle the lowest-numbered pending lane is drained onto
//   score/score_lane with a score_valid pulse, and the combo counters are
//   updated from the drained code.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   btn            debounced button levels, bit i = lane i
//   note_present   note in judge zone, bit i = lane i
//   offset         per-lane note offsets, lane i at [i*OFF_W +: OFF_W]
//   delete_note    per-lane one-cycle pulse: remove the judged note
//   score_valid    one-cycle pulse: score/score_lane/combo just updated
//   score          11 PERFECT, 10 LATE, 01 EARLY, 00 NONE/MISS
//   score_lane     lane of the current score
//   combo          consecutive non-miss count, saturating
//   max_combo      highest combo since reset
//   overflow       sticky: an undrained result was overwritten
module hit_judge_multi
  import hit_pkg::*;
#(
  parameter int N_LANES   = 2,
  parameter int OFF_W     = 3,
  parameter int EARLY_OFF = DEF_EARLY_OFF,
  parameter int PERF_LO   = DEF_PERF_LO,
  parameter int PERF_HI   = DEF_PERF_HI,
  parameter int LATE_OFF  = DEF_LATE_OFF,
  parameter int MISS_OFF  = DEF_MISS_OFF,
  parameter int CW        = 8,
  localparam int LW       = lane_w(N_LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_LANES-1:0]       btn,
  input  logic [N_LANES-1:0]       note_present,
  input  logic [N_LANES*OFF_W-1:0] offset,
  output logic [N_LANES-1:0]       delete_note,
  output logic                     score_valid,
  output score_t                   score,
  output logic [LW-1:0]            score_lane,
  output logic [CW-1:0]            combo,
  output logic [CW-1:0]            max_combo,
  output logic                     overflow
);

  localparam logic [CW-1:0] COMBO_MAX = {CW{1'b1}};

  logic [N_LANES-1:0] pend_valid;
  score_t             pend_code [N_LANES];
  logic [N_LANES-1:0] drain_vec;
  logic [N_LANES-1:0] ovf_evt;
  logic               drain_any;
  logic [LW-1:0]      drain_idx;
  score_t             drain_code;
  logic [CW-1:0]      combo_next;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    judge_lane #(
      .OFF_W    (OFF_W),
      .EARLY_OFF(EARLY_OFF),
      .PERF_LO  (PERF_LO),
      .PERF_HI  (PERF_HI),
      .LATE_OFF (LATE_OFF),
      .MISS_OFF (MISS_OFF)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn[g]),
      .note_present(note_present[g]),
      .offset      (offset[g*OFF_W +: OFF_W]),
      .drain       (drain_vec[g]),
      .delete_note (delete_note[g]),
      .pend_valid  (pend_valid[g]),
      .pend_code   (pend_code[g]),
      .ovf_evt     (ovf_evt[g])
    );
  end

  // Fixed priority: the lowest-index valid lane wins the single drain slot.
  always_comb begin
    drain_any  = 1'b0;
    drain_idx  = '0;
    drain_code = SCORE_NONE;
    drain_vec  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (pend_valid[i] && !drain_any) begin
        drain_any    = 1'b1;
        drain_idx    = LW'(i);
        drain_code   = pend_code[i];
        drain_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    combo_next = '0;
    if (drain_code != SCORE_NONE)
      combo_next = (combo == COMBO_MAX) ? combo : combo + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_valid <= 1'b0;
      score       <= SCORE_NONE;
      score_lane  <= '0;
      combo       <= '0;
      max_combo   <= '0;
      overflow    <= 1'b0;
    end else begin
      score_valid <= drain_any;
      if (drain_any) begin
        score      <= drain_code;
        score_lane <= drain_idx;
        combo      <= combo_next;
        if (combo_next > max_combo) max_combo <= combo_next;
      end
      if (|ovf_evt) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_judge_multi.sv
// tb_hit_judge_multi: bench for hit_judge_multi with 4 lanes and a 3-bit combo.
module tb_hit_judge_multi;

  localparam int NL    = 4;
  localparam int OW    = 3;
  localparam int CWT   = 3;
  localparam int CMAX  = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NL-1:0]     btn = '0;
  logic [NL-1:0]     note_present = '0;
  logic [NL*OW-1:0]  offset = '0;
  logic [NL-1:0]     delete_note;
  logic              score_valid;
  logic [1:0]        score;
  logic [1:0]        score_lane;
  logic [CWT-1:0]    combo;
  logic [CWT-1:0]    max_combo;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hit_judge_multi #(.N_LANES(NL), .OFF_W(OW), .CW(CWT)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .note_present(note_present),
    .offset      (offset),
    .delete_note (delete_note),
    .score_valid (score_valid),
    .score       (score),
    .score_lane  (score_lane),
    .combo       (combo),
    .max_combo   (max_combo),
    .overflow    (overflow)
  );

  // ---------------- reference model ----------------
  // Each lane is a one-slot mailbox; each cycle the lowest lane with mail
  // is emptied onto the score outputs, then this cycle's events post mail.
  logic [3:0]  exp_q[$];
  logic [NL-1:0] m_btn_q;
  bit          m_full [NL];
  int          m_mail [NL];
  logic [NL-1:0] exp_del;
  bit          exp_sv;
  int          exp_score, exp_lane, exp_combo, exp_max;
  bit          exp_ovf;
  int          m_d, m_code;
  bit          m_press, m_ev;

  function automatic int judge(input int o);
    if (o >= 2 && o <= 4) return 3;
    if (o == 5) return 2;
    if (o == 1) return 1;
    return 0;
  endfunction

  function automatic int off_of(input int lane);
    return int'(offset[lane*OW +: OW]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_btn_q = '0; exp_del = '0; exp_sv = 0; exp_score = 0; exp_lane = 0;
      exp_combo = 0; exp_max = 0; exp_ovf = 0;
      for (int i = 0; i < NL; i++) begin m_full[i] = 0; m_mail[i] = 0; end
      exp_q.delete();
    end else begin
      m_d = -1;
      for (int i = NL - 1; i >= 0; i--) if (m_full[i]) m_d = i;
      exp_sv = (m_d >= 0);
      if (m_d >= 0) begin
        exp_score = m_mail[m_d];
        exp_lane  = m_d;
        exp_combo = (exp_score != 0) ? ((exp_combo + 1 > CMAX) ? CMAX : exp_combo + 1) : 0;
        if (exp_combo > exp_max) exp_max = exp_combo;
        m_full[m_d] = 0;
        exp_q.push_back({2'(m_d), 2'(exp_score)});
      end
      for (int i = 0; i < NL; i++) begin
        m_press = btn[i] && !m_btn_q[i];
        m_ev = note_present[i] && (m_press || off_of(i) == 6);
        m_code = m_press ? judge(off_of(i)) : 0;
        exp_del[i] = m_ev;
        if (m_ev) begin
          if (m_full[i]) exp_ovf = 1;   // still full: drained slot was cleared above
          m_full[i] = 1;
          m_mail[i] = m_code;
        end
      end
      m_btn_q = btn;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_off(input int lane, input int v);
    offset[lane*OW +: OW] = OW'(v);
  endtask

  task automatic clear_inputs();
    btn = '0; note_present = '0; offset = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    btn = 4'b0001; note_present = 4'b0001; set_off(0, 3);
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({delete_note, score_valid, score, score_lane, combo, max_combo, overflow} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got del=%b sv=%b sc=%b ln=%0d cb=%0d mx=%0d ov=%b exp all 0",
               delete_note, score_valid, score, score_lane, combo, max_combo, overflow);
    end
    tick();
    rst = 1'b0;   // button stays held through release: counts as a press
    tick();
    n_checks++;
    if (delete_note !== 4'b0001) begin
      n_errors++; $display("FAIL held_press_del got=%b exp=0001", delete_note);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (score_valid !== 1'b1 || score !== 2'b11 || score_lane !== 2'd0 || combo !== 3'd1) begin
      n_errors++;
      $display("FAIL held_press_score got sv=%b sc=%b ln=%0d cb=%0d exp 1 11 0 1",
               score_valid, score, score_lane, combo);
    end
  endtask

  task automatic test_single_perfect();
    do_reset();
    btn[0] = 1'b1; note_present[0] = 1'b1; set_off(0, 3);
    tick();
    n_checks++;
    if (delete_note !== 4'b0001 || score_valid !== 1'b0) begin
      n_errors++; $display("FAIL perfect_del got del=%b sv=%b exp 0001 0", delete_note, score_valid);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (delete_note !== 4'b0000 || score_valid !== 1'b1 || score !== 2'b11 ||
        score_lane !== 2'd0 || combo !== 3'd1) begin
      n_errors++;
      $display("FAIL perfect_score got del=%b sv=%b sc=%b ln=%0d cb=%0d exp 0000 1 11 0 1",
               delete_note, score_valid, score, score_lane, combo);
    end
    tick();
    n_checks++;
    if (score_valid !== 1'b0 || score !== 2'b11 || combo !== 3'd1) begin
      n_errors++; $display("FAIL perfect_hold got sv=%b sc=%b cb=%0d exp 0 11 1", score_valid, score, combo);
    end
  endtask

  task automatic test_dual_press();
    do_reset();
    btn = 4'b0011; note_present = 4'b0011; set_off(0, 5); set_off(1, 1);
    tick();
    n_checks++;
    if (delete_note !== 4'b0011) begin
      n_errors++; $display("FAIL dual_del got=%b exp=0011", delete_note);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (score_valid !== 1'b1 || score !== 2'b10 || score_lane !== 2'd0 || combo !== 3'd1) begin
      n_errors++;
      $display("FAIL dual_first got sv=%b sc=%b ln=%0d cb=%0d exp 1 10 0 1", score_valid, score, score_lane, combo);
    end
    tick();
    n_checks++;
    if (score_valid !== 1'b1 || score !== 2'b01 || score_lane !== 2'd1 || combo !== 3'd2) begin
      n_errors++;
      $display("FAIL dual_second got sv=%b sc=%b ln=%0d cb=%0d exp 1 01 1 2", score_valid, score, score_lane, combo);
    end
  endtask

  // Runs straight after test_dual_press, so combo and max_combo start at 2.
  task automatic test_auto_miss();
    note_present[1] = 1'b1; set_off(1, 6);
    tick();
    n_checks++;
    if (delete_note !== 4'b0010) begin
      n_errors++; $display("FAIL miss_del got=%b exp=0010", delete_note);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (score_valid !== 1'b1 || score !== 2'b00 || score_lane !== 2'd1 ||
        combo !== 3'd0 || max_combo !== 3'd2) begin
      n_errors++;
      $display("FAIL miss_score got sv=%b sc=%b ln=%0d cb=%0d mx=%0d exp 1 00 1 0 2",
               score_valid, score, score_lane, combo, max_combo);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      btn[0] = 1'b1; note_present[0] = 1'b1; set_off(0, $urandom_range(2, 4));
      tick();
      clear_inputs();
      tick();
    end
    n_checks++;
    if (combo !== 3'd7 || max_combo !== 3'd7) begin
      n_errors++; $display("FAIL sat_combo got cb=%0d mx=%0d exp 7 7", combo, max_combo);
    end
    btn[0] = 1'b1; note_present[0] = 1'b1; set_off(0, 0);
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (score !== 2'b00 || combo !== 3'd0 || max_combo !== 3'd7) begin
      n_errors++; $display("FAIL sat_miss got sc=%b cb=%0d mx=%0d exp 00 0 7", score, combo, max_combo);
    end
  endtask

  task automatic test_starvation();
    bit starved_ok;
    do_reset();
    note_present = 4'b1001; set_off(0, 6); set_off(3, 3);
    btn[3] = 1'b1;
    tick();
    btn[3] = 1'b0;
    tick();
    btn[3] = 1'b1;
    tick();
    starved_ok = 1;
    for (int k = 0; k < 5; k++) begin
      if (score_valid !== 1'b1 || score_lane !== 2'd0) starved_ok = 0;
      tick();
    end
    n_checks++;
    if (!starved_ok) begin
      n_errors++; $display("FAIL starve_lane0 lane 3 drained or gap while lane 0 busy, last ln=%0d", score_lane);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++; $display("FAIL starve_overflow got=%b exp=1", overflow);
    end
    clear_inputs();
    tick();
    tick();
    n_checks++;
    if (score_valid !== 1'b1 || score_lane !== 2'd3 || score !== 2'b11) begin
      n_errors++; $display("FAIL starve_release got sv=%b ln=%0d sc=%b exp 1 3 11", score_valid, score_lane, score);
    end
  endtask

  task automatic test_reset_pending();
    bit quiet;
    do_reset();
    btn = 4'b0111; note_present = 4'b0111; set_off(0, 3); set_off(1, 3); set_off(2, 3);
    tick();
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({delete_note, score_valid, score, score_lane, combo, max_combo, overflow} !== '0) begin
      n_errors++; $display("FAIL rstpend_outputs got del=%b sv=%b exp 0", delete_note, score_valid);
    end
    tick();
    rst = 1'b0;
    quiet = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (score_valid !== 1'b0) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_errors++; $display("FAIL rstpend_quiet score_valid seen after reset, exp none");
    end
  endtask

  task automatic test_random();
    logic [3:0] item;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      btn = 4'($urandom_range(0, 15));
      note_present = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int l = 0; l < NL; l++) set_off(l, $urandom_range(0, 7));
      tick();
      n_checks++;
      if (delete_note !== exp_del) begin
        n_errors++; $display("FAIL rand_del cyc=%0d got=%b exp=%b", c, delete_note, exp_del);
      end
      n_checks++;
      if (score_valid !== exp_sv) begin
        n_errors++; $display("FAIL rand_sv cyc=%0d got=%b exp=%b", c, score_valid, exp_sv);
      end
      if (score_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL rand_sb cyc=%0d got ln=%0d sc=%b exp nothing", c, score_lane, score);
        end else begin
          item = exp_q.pop_front();
          if ({score_lane, score} !== item) begin
            n_errors++; $display("FAIL rand_sb cyc=%0d got=%h exp=%h", c, {score_lane, score}, item);
          end
        end
      end
      n_checks++;
      if (combo !== CWT'(exp_combo) || max_combo !== CWT'(exp_max)) begin
        n_errors++;
        $display("FAIL rand_combo cyc=%0d got cb=%0d mx=%0d exp %0d %0d", c, combo, max_combo, exp_combo, exp_max);
      end
      n_checks++;
      if (overflow !== exp_ovf) begin
        n_errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", c, overflow, exp_ovf);
      end
    end
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (score_valid === 1'b1 && exp_q.size() != 0) item = exp_q.pop_front();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL rand_drain got %0d results never scored exp 0", exp_q.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_perfect();
    test_dual_press();
    test_auto_miss();
    test_saturation();
    test_starvation();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
